// File: rtl/axil_ram_slave.sv
// AXI4-Lite slave backed by a word-addressed RAM with byte strobes.
// Independent read and write FSMs, programmable read latency.
module axil_ram_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IDXW   = $clog2(DEPTH);
    localparam int BYTES  = DEPTH * STRB_W;
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(BYTES);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_COMMIT,
        W_RESP
    } w_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Held low for the first cycle out of reset so the readies rise one edge later.
    logic live;

    always_ff @(posedge clk) begin
        if (!rst) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    r_state_t              r_state;
    r_state_t              r_next;
    logic [1:0]            r_cnt;
    logic [1:0]            r_cnt_next;
    logic                  arready_q;
    logic                  ar_fire;
    logic                  ar_oor;
    logic [IDXW-1:0]       ar_idx;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    assign ar_fire = ARVALID && arready_q;
    assign ar_idx  = ARADDR[OFFS +: IDXW];
    assign ar_oor  = {1'b0, ARADDR} >= LIMIT;

    always_comb begin
        r_next     = r_state;
        r_cnt_next = r_cnt;
        unique case (r_state)
            R_IDLE: begin
                if (ar_fire) begin
                    if (RD_LATENCY > 1) begin
                        r_next     = R_WAIT;
                        r_cnt_next = 2'(RD_LATENCY - 2);
                    end else begin
                        r_next = R_RESP;
                    end
                end
            end
            R_WAIT: begin
                if (r_cnt == 2'd0) begin
                    r_next = R_RESP;
                end else begin
                    r_cnt_next = r_cnt - 2'd1;
                end
            end
            R_RESP: begin
                if (RREADY) begin
                    r_next = R_IDLE;
                end
            end
            default: begin
                r_next = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= R_IDLE;
            r_cnt     <= 2'd0;
            arready_q <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            r_state   <= r_next;
            r_cnt     <= r_cnt_next;
            arready_q <= live && (r_next == R_IDLE);
            if (ar_fire) begin
                rdata_q <= ar_oor ? '0 : mem[ar_idx];
                rresp_q <= ar_oor ? SLVERR : OKAY;
            end
        end
    end

    assign ARREADY = arready_q;
    assign RVALID  = (r_state == R_RESP);
    assign RDATA   = RVALID ? rdata_q : '0;
    assign RRESP   = rresp_q;

    w_state_t              w_state;
    w_state_t              w_next;
    logic                  aw_got;
    logic                  w_got;
    logic                  aw_got_next;
    logic                  w_got_next;
    logic                  awready_q;
    logic                  wready_q;
    logic                  aw_fire;
    logic                  w_fire;
    logic                  aw_oor;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic [1:0]            bresp_q;

    assign aw_fire = AWVALID && awready_q;
    assign w_fire  = WVALID && wready_q;
    assign aw_oor  = {1'b0, awaddr_q} >= LIMIT;

    always_comb begin
        w_next      = w_state;
        aw_got_next = aw_got;
        w_got_next  = w_got;
        unique case (w_state)
            W_IDLE: begin
                aw_got_next = aw_got || aw_fire;
                w_got_next  = w_got || w_fire;
                if (aw_got_next && w_got_next) begin
                    w_next = W_COMMIT;
                end
            end
            W_COMMIT: begin
                w_next = W_RESP;
            end
            W_RESP: begin
                if (BREADY) begin
                    w_next      = W_IDLE;
                    aw_got_next = 1'b0;
                    w_got_next  = 1'b0;
                end
            end
            default: begin
                w_next      = W_IDLE;
                aw_got_next = 1'b0;
                w_got_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state   <= W_IDLE;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= OKAY;
        end else begin
            w_state   <= w_next;
            aw_got    <= aw_got_next;
            w_got     <= w_got_next;
            awready_q <= live && (w_next == W_IDLE) && !aw_got_next;
            wready_q  <= live && (w_next == W_IDLE) && !w_got_next;
            if (aw_fire) begin
                awaddr_q <= AWADDR;
            end
            if (w_fire) begin
                wdata_q <= WDATA;
                wstrb_q <= WSTRB;
            end
            if (w_state == W_COMMIT) begin
                bresp_q <= aw_oor ? SLVERR : OKAY;
            end
        end
    end

    // RAM is never cleared; a reset landing on the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (rst && (w_state == W_COMMIT) && !aw_oor) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb_q[i]) begin
                    mem[awaddr_q[OFFS +: IDXW]][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = (w_state == W_RESP);
    assign BRESP   = bresp_q;

endmodule

// File: tb/tb_axil_ram_slave.sv
// Randomized bench for axil_ram_slave against a byte-array memory model.
module tb_axil_ram_slave;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic [31:0] AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;

    int checks = 0;
    int errors = 0;

    bit [7:0] bmem [1024];

    axil_ram_slave #(
        .DATA_WIDTH(32),
        .DEPTH(256),
        .ADDR_WIDTH(32),
        .RD_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ARADDR(ARADDR),
        .ARVALID(ARVALID),
        .ARREADY(ARREADY),
        .RDATA(RDATA),
        .RRESP(RRESP),
        .RVALID(RVALID),
        .RREADY(RREADY),
        .AWADDR(AWADDR),
        .AWVALID(AWVALID),
        .AWREADY(AWREADY),
        .WDATA(WDATA),
        .WSTRB(WSTRB),
        .WVALID(WVALID),
        .WREADY(WREADY),
        .BRESP(BRESP),
        .BVALID(BVALID),
        .BREADY(BREADY)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        logic [31:0] b;
        if (addr >= 32'h400) return 32'h0;
        b = addr & 32'h3FC;
        return {bmem[b+3], bmem[b+2], bmem[b+1], bmem[b]};
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] addr);
        return (addr >= 32'h400) ? 2'b10 : 2'b00;
    endfunction

    function automatic void model_write(input logic [31:0] addr,
                                        input logic [31:0] data,
                                        input logic [3:0] strb);
        logic [31:0] b;
        if (addr < 32'h400) begin
            b = addr & 32'h3FC;
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) bmem[b+i] = data[8*i +: 8];
            end
        end
    endfunction

    task automatic send_aw(input logic [31:0] addr, input int dly);
        int n = 0;
        repeat (dly) @(negedge clk);
        AWADDR  = addr;
        AWVALID = 1'b1;
        while (!AWREADY && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!AWREADY) chk("aw_timeout", AWREADY, 1);
        @(negedge clk);
        AWVALID = 1'b0;
        chk("awready_drop", AWREADY, 0);
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb,
                          input int dly);
        int n = 0;
        repeat (dly) @(negedge clk);
        WDATA  = data;
        WSTRB  = strb;
        WVALID = 1'b1;
        while (!WREADY && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!WREADY) chk("w_timeout", WREADY, 1);
        @(negedge clk);
        WVALID = 1'b0;
        chk("wready_drop", WREADY, 0);
    endtask

    // mode 0: AW and W together, 1: AW leads by gap, 2: W leads by gap
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int mode,
                            input int gap, input int bwait);
        int da;
        int dw;
        logic [1:0] exp;
        da  = (mode == 2) ? gap : 0;
        dw  = (mode == 1) ? gap : 0;
        exp = model_resp(addr);
        BREADY = 1'b0;
        fork
            send_aw(addr, da);
            send_w(data, strb, dw);
        join
        chk("bvalid_early", BVALID, 0);
        @(negedge clk);
        chk("bvalid", BVALID, 1);
        chk("bresp", BRESP, exp);
        repeat (bwait) begin
            @(negedge clk);
            chk("bvalid_hold", BVALID, 1);
            chk("bresp_hold", BRESP, exp);
        end
        BREADY = 1'b1;
        @(negedge clk);
        BREADY = 1'b0;
        chk("bvalid_clr", BVALID, 0);
        model_write(addr, data, strb);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_d,
                           input logic [1:0] exp_r, input int stall);
        int n = 0;
        ARADDR  = addr;
        ARVALID = 1'b1;
        while (!ARREADY && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ARREADY) begin
            chk("ar_timeout", ARREADY, 1);
            ARVALID = 1'b0;
        end else begin
            @(negedge clk);
            ARVALID = 1'b0;
            for (int k = 1; k < LAT; k++) begin
                chk("rvalid_early", RVALID, 0);
                chk("rdata_idle", RDATA, 0);
                chk("arready_busy", ARREADY, 0);
                @(negedge clk);
            end
            chk("rvalid", RVALID, 1);
            chk("rdata", RDATA, exp_d);
            chk("rresp", RRESP, exp_r);
            RREADY = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                chk("rvalid_hold", RVALID, 1);
                chk("rdata_hold", RDATA, exp_d);
                chk("rresp_hold", RRESP, exp_r);
                chk("arready_hold", ARREADY, 0);
            end
            RREADY = 1'b1;
            @(negedge clk);
            RREADY = 1'b0;
            chk("rvalid_clr", RVALID, 0);
            chk("rdata_zero", RDATA, 0);
            chk("arready_back", ARREADY, 1);
        end
    endtask

    task automatic rd_model(input logic [31:0] addr, input int stall);
        do_read(addr, model_word(addr), model_resp(addr), stall);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_arready"}, ARREADY, 0);
        chk({tag, "_awready"}, AWREADY, 0);
        chk({tag, "_wready"}, WREADY, 0);
        chk({tag, "_rvalid"}, RVALID, 0);
        chk({tag, "_bvalid"}, BVALID, 0);
        chk({tag, "_rdata"}, RDATA, 0);
        chk({tag, "_rresp"}, RRESP, 0);
        chk({tag, "_bresp"}, BRESP, 0);
    endtask

    task automatic release_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rel1_arready", ARREADY, 0);
        chk("rel1_awready", AWREADY, 0);
        chk("rel1_wready", WREADY, 0);
        @(negedge clk);
        chk("rel2_arready", ARREADY, 1);
        chk("rel2_awready", AWREADY, 1);
        chk("rel2_wready", WREADY, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        release_reset();

        for (int w = 0; w < 256; w++) begin
            do_write(32'(w * 4), $urandom, 4'hF, w % 3, w % 3, 0);
        end

        do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_read(32'h10, 32'hDEADBEEF, 2'b00, 0);
        do_write(32'h10, 32'h00000011, 4'h1, 1, 2, 1);
        do_read(32'h10, 32'hDEADBE11, 2'b00, 0);
        do_read(32'h400, 32'h0, 2'b10, 1);
        do_write(32'h400, 32'h12345678, 4'hF, 2, 1, 0);
        rd_model(32'h0, 0);
        do_write(32'h13, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
        do_read(32'h10, 32'hDEADBE11, 2'b00, 5);

        fork
            do_write(32'h30, 32'hCAFEF00D, 4'hF, 0, 0, 0);
            begin
                repeat (3) @(negedge clk);
                do_read(32'h30, 32'hCAFEF00D, 2'b00, 0);
            end
        join

        do_write(32'h20, 32'h1, 4'hF, 0, 0, 0);
        fork
            do_write(32'h20, 32'h2, 4'hF, 0, 0, 0);
            begin
                @(negedge clk);
                do_read(32'h20, 32'h1, 2'b00, 0);
            end
        join
        do_read(32'h20, 32'h2, 2'b00, 0);

        chk("ab_awready", AWREADY, 1);
        AWADDR  = 32'h40;
        WDATA   = 32'hA5A5A5A5;
        WSTRB   = 4'hF;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        @(negedge clk);
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        check_reset_outputs("abw");
        release_reset();
        rd_model(32'h40, 0);

        chk("rw_arready", ARREADY, 1);
        ARADDR  = 32'h10;
        ARVALID = 1'b1;
        @(negedge clk);
        ARVALID = 1'b0;
        chk("rw_rvalid_wait", RVALID, 0);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rw");
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rw_no_resp", RVALID, 0);
        end
        do_read(32'h10, 32'hDEADBE11, 2'b00, 0);

        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                a = 32'h400 + 32'($urandom_range(0, 8191));
            end else begin
                a = 32'($urandom_range(0, 1023));
            end
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                do_write(a, d, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 2), $urandom_range(0, 3),
                         $urandom_range(0, 2));
            end else begin
                rd_model(a, $urandom_range(0, 3));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_ram_slave.md
AXIL_RAM_SLAVE -- requirements
Module: axil_ram_slave

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, meaning data bus width in bits (32 or 64).
REQ-002 SHALL provide parameter DEPTH, default 256, meaning memory size in words (power of two).
REQ-003 SHALL provide parameter ADDR_WIDTH, default 32, meaning byte address width.
REQ-004 SHALL provide parameter RD_LATENCY, default 1, meaning cycles from AR handshake to RVALID (1..4).
REQ-005 SHALL have ports, one per line:
 clk  in  1  clock, all logic on rising edge
 rst  in  1  reset, synchronous, active-low
 ARADDR  in  ADDR_WIDTH  read byte address
 ARVALID  in  1  read address valid
 ARREADY  out  1  read address ready
 RDATA  out  DATA_WIDTH  read data
 RRESP  out  2  read response
 RVALID  out  1  read data valid
 RREADY  in  1  read data ready
 AWADDR  in  ADDR_WIDTH  write byte address
 AWVALID  in  1  write address valid
 AWREADY  out  1  write address ready
 WDATA  in  DATA_WIDTH  write data
 WSTRB  in  DATA_WIDTH/8  byte write enables
 WVALID  in  1  write data valid
 WREADY  out  1  write data ready
 BRESP  out  2  write response
 BVALID  out  1  write response valid
 BREADY  in  1  write response ready

Function
REQ-006 SHALL derive word index as addr[log2(DATA_WIDTH/8) +: log2(DEPTH)]; low byte-offset bits are ignored (no misalignment error).
REQ-007 SHALL flag an access out of range when addr >= DEPTH*DATA_WIDTH/8; response then SLVERR (2'b10), else OKAY (2'b00).
REQ-008 Read FSM SHALL have states R_IDLE, R_WAIT, R_RESP; ARREADY=1 only in R_IDLE.
REQ-009 On ARVALID&&ARREADY the block SHALL sample mem[index] (0 if out of range) and RRESP in that cycle, and move to R_WAIT.
REQ-010 RVALID SHALL assert exactly RD_LATENCY cycles after the AR handshake edge (R_WAIT lasts RD_LATENCY-1 cycles; skipped when RD_LATENCY=1).
REQ-011 RDATA/RRESP SHALL stay stable while RVALID=1 and RREADY=0; RDATA SHALL be 0 whenever RVALID=0.
REQ-012 On RVALID&&RREADY the FSM SHALL return to R_IDLE; ARREADY re-asserts the following cycle (one outstanding read, max throughput one read per RD_LATENCY+1 cycles).
REQ-013 Write FSM SHALL have states W_IDLE, W_COMMIT, W_RESP; AWREADY=1 in W_IDLE until AW captured, WREADY=1 in W_IDLE until W captured; AW and W accepted independently, either order or same cycle.
REQ-014 In W_COMMIT (one cycle after both captured) the block SHALL write bytes with WSTRB[i]=1 to mem[index]; out-of-range SHALL write nothing.
REQ-015 BVALID SHALL assert the cycle after W_COMMIT with BRESP per REQ-007, held until BREADY; on BVALID&&BREADY return to W_IDLE.
REQ-016 Read and write FSMs SHALL be independent; a read sampling in the same cycle as a write commit to the same word SHALL return the old value (read-before-write).
REQ-017 WSTRB=0 SHALL complete normally with OKAY and leave memory unchanged.

Reset
REQ-018 While rst=0 at a clock edge: ARREADY, RVALID, AWREADY, WREADY, BVALID=0; RDATA=0; RRESP=BRESP=2'b00; both FSMs to IDLE.
REQ-019 Reset mid-transaction SHALL abandon it (uncommitted write dropped); memory contents SHALL NOT be reset.
REQ-020 First cycle after rst=1: outputs still reset values; ARREADY/AWREADY/WREADY rise on the following edge.

Verification
REQ-021 Write AW=0x10, W=0xDEADBEEF, WSTRB=0xF, BREADY=1 -> BVALID one cycle after commit, BRESP=00; read 0x10 -> RDATA=0xDEADBEEF, RRESP=00, RVALID RD_LATENCY cycles after AR.
REQ-022 Write 0x10 with WDATA=0x00000011, WSTRB=0x1 -> read 0x10 returns 0xDEADBE11.
REQ-023 Read 0x400 (DEPTH=256, 32-bit) -> RRESP=10, RDATA=0; write 0x400 -> BRESP=10, no memory change.
REQ-024 RREADY held 0 for 5 cycles with RVALID=1 -> RDATA/RRESP constant, ARREADY=0 throughout; AW/W presented 3 cycles before AR -> both accepted, same response.
REQ-025 Same-cycle AR to 0x20 and write commit 0x20 (old 0x1, new 0x2) -> RDATA=0x1, later read 0x2; rst=0 asserted during R_WAIT -> RVALID=0 next edge, no response delivered.
